// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one 1R1W RAM between two write clients and two read clients.
//   Writes and reads are arbitrated independently with 1-bit round-robin
//   pointers, so one write and one read can be granted in the same cycle.
//   A read that targets the address being written in the same cycle is held
//   off for one cycle, so it returns the freshly written data.
//   Read data comes back two cycles after the grant, tagged with the
//   requesting client through a small valid/ID shift pipeline.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   wN_req/wN_addr/wN_data       write request per client (N = 0,1)
//   wN_gnt                       combinational write grant
//   rN_req/rN_addr               read request per client
//   rN_gnt                       combinational read grant
//   rN_valid                     registered read-return strobe per client
//   rd_data                      read-return data (ram_q passed through)
//   ram_wren/ram_wraddress/ram_data/ram_rdaddress/ram_q   RAM wrapper side
module ram_port_arbiter #(
    parameter int DAT_WIDTH  = 36,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w0_req,
    input  logic                  w1_req,
    input  logic [ADDR_WIDTH-1:0] w0_addr,
    input  logic [ADDR_WIDTH-1:0] w1_addr,
    input  logic [DAT_WIDTH-1:0]  w0_data,
    input  logic [DAT_WIDTH-1:0]  w1_data,
    output logic                  w0_gnt,
    output logic                  w1_gnt,
    input  logic                  r0_req,
    input  logic                  r1_req,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    output logic                  r0_gnt,
    output logic                  r1_gnt,
    output logic                  r0_valid,
    output logic                  r1_valid,
    output logic [DAT_WIDTH-1:0]  rd_data,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_wraddress,
    output logic [DAT_WIDTH-1:0]  ram_data,
    output logic [ADDR_WIDTH-1:0] ram_rdaddress,
    input  logic [DAT_WIDTH-1:0]  ram_q
);

    // Round-robin pointers: the client named by the pointer wins a tie.
    logic wr_pri;
    logic rd_pri;

    logic w_any;    // some write request present (and not in reset)
    logic w_sel;    // write winner is client 1
    logic r_any;    // some read request present (and not in reset)
    logic r_sel;    // read winner is client 1
    logic hazard;   // read winner collides with this cycle's write
    logic r_fire;   // a read grant is issued this cycle

    // Read-return pipeline: stage 1 is one cycle after grant, stage 2 is
    // the cycle ram_q carries the data.
    logic [2:1] vld_pipe;
    logic [2:1] id_pipe;

    always_comb begin
        w_any  = !rst && (w0_req || w1_req);
        w_sel  = !rst && w1_req && (!w0_req || wr_pri);
        r_any  = !rst && (r0_req || r1_req);
        r_sel  = !rst && r1_req && (!r0_req || rd_pri);

        w0_gnt = w_any && !w_sel;
        w1_gnt = w_any && w_sel;

        ram_wren      = w0_gnt || w1_gnt;
        ram_wraddress = w1_gnt ? w1_addr : w0_addr;
        ram_data      = w1_gnt ? w1_data : w0_data;
        ram_rdaddress = r_sel  ? r1_addr : r0_addr;

        // Same-address read/write in one cycle: the write wins and the read
        // retries next cycle, so it never sees pre-write data.
        hazard = ram_wren && r_any && (ram_rdaddress == ram_wraddress);

        r0_gnt = r_any && !r_sel && !hazard;
        r1_gnt = r_any &&  r_sel && !hazard;
        r_fire = r0_gnt || r1_gnt;

        r0_valid = vld_pipe[2] && !id_pipe[2];
        r1_valid = vld_pipe[2] &&  id_pipe[2];
        rd_data  = ram_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_pri   <= 1'b0;
            rd_pri   <= 1'b0;
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            if (w_any)
                wr_pri <= !w_sel;
            if (r_fire)
                rd_pri <= !r_sel;
            vld_pipe <= {vld_pipe[1], r_fire};
            id_pipe  <= {id_pipe[1],  r1_gnt};
        end
    end

endmodule
